// File: rtl/grf_writeback_sink_pkg.sv
// grf_writeback_sink_pkg
// Shared constants for the general-purpose register file writeback sink:
// default geometry, the hardwired-zero register number, the register-number
// width, and the reset values of the trace record.
package grf_writeback_sink_pkg;

  localparam int GRF_NUM_REGS = 32;
  localparam int GRF_DW       = 32;
  localparam int REG_AW       = 5;

  localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

  localparam logic [31:0]       TRACE_PC_RST   = 32'h0000_0000;
  localparam logic [REG_AW-1:0] TRACE_ADDR_RST = 5'd0;
  localparam logic [31:0]       WR_COUNT_RST   = 32'h0000_0000;

endpackage

// File: rtl/grf_writeback_sink_if.sv
// grf_writeback_sink_if
// Writeback bus from the W stage into the register file.
//   RFWr  : write enable
//   A3    : destination register number
//   WData : value to write
//   PC_W  : PC of the instruction in W (trace only)
// Modports: master (W stage, drives), slave (register file, receives).
interface grf_writeback_sink_if #(
  parameter int DW = 32
);
  logic          RFWr;
  logic [4:0]    A3;
  logic [DW-1:0] WData;
  logic [31:0]   PC_W;

  modport master (output RFWr, output A3, output WData, output PC_W);
  modport slave  (input  RFWr, input  A3, input  WData, input  PC_W);
endinterface

// File: rtl/grf_writeback_sink_read_port.sv
// grf_read_port
// One combinational read port of the register file. Applies the $0 rule and,
// when GRF_BYPASS_EN is defined, the write-first W->D bypass.
//   addr     : register number being read
//   arr_data : array contents at addr
//   we_eff   : effective write this cycle (already masked by reset)
//   wr_addr  : write destination
//   wr_data  : write value
//   rd       : read result
// Configuration macro: GRF_BYPASS_EN.
module grf_read_port
  import grf_writeback_sink_pkg::*;
#(
  parameter int DW = GRF_DW
) (
  input  logic [REG_AW-1:0] addr,
  input  logic [DW-1:0]     arr_data,
  input  logic              we_eff,
  input  logic [REG_AW-1:0] wr_addr,
  input  logic [DW-1:0]     wr_data,
  output logic [DW-1:0]     rd
);

`ifdef GRF_BYPASS_EN
  always_comb begin
    rd = arr_data;
    if (addr == REG_ZERO) begin
      rd = '0;
    end else if (we_eff && (wr_addr == addr)) begin
      rd = wr_data;
    end
  end
`else
  // Without bypass the write-port signals are not consumed; fold them into a
  // sink so the port list stays identical across both builds.
  logic unused_wr;
  assign unused_wr = ^{we_eff, wr_addr, wr_data};

  always_comb begin
    rd = arr_data;
    if (addr == REG_ZERO) begin
      rd = '0;
    end
  end
`endif

endmodule

// File: rtl/grf_writeback_sink.sv
// grf_writeback_sink
// MIPS general-purpose register file sitting in D, fed by the W-stage
// writeback bus. Two combinational read ports, optional same-cycle W->D
// bypass, and a registered per-write trace record plus write counter.
//   clk, reset   : clock, asynchronous active-high reset
//   A1, A2       : read register numbers
//   RD1, RD2     : read data
//   wb           : writeback bus (RFWr, A3, WData, PC_W), slave side
//   trace_valid  : one-cycle pulse after each effective write
//   trace_pc/addr/data : fields of the last effective write
//   wr_count     : effective writes since reset (wraps)
// Configuration macro: GRF_BYPASS_EN (enables the write-first bypass).
module grf_writeback_sink
  import grf_writeback_sink_pkg::*;
#(
  parameter int NUM_REGS = GRF_NUM_REGS,
  parameter int DW       = GRF_DW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] A1,
  input  logic [REG_AW-1:0] A2,
  output logic [DW-1:0]     RD1,
  output logic [DW-1:0]     RD2,
  grf_writeback_sink_if.slave wb,
  output logic              trace_valid,
  output logic [31:0]       trace_pc,
  output logic [REG_AW-1:0] trace_addr,
  output logic [DW-1:0]     trace_data,
  output logic [31:0]       wr_count
);

  logic [DW-1:0] regs [NUM_REGS];
  logic [31:0]   wr_count_q;
  logic          we_eff;
  logic          we_byp;

  // Writes to $0 are dropped entirely: no array update, trace or count.
  assign we_eff = wb.RFWr && (wb.A3 != REG_ZERO);
  // While reset is held the bypass must not leak WData onto the read ports.
  assign we_byp = we_eff && !reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (we_eff) begin
      regs[wb.A3] <= wb.WData;
    end
  end

  // Trace record and write counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      trace_valid <= 1'b0;
      trace_pc    <= TRACE_PC_RST;
      trace_addr  <= TRACE_ADDR_RST;
      trace_data  <= '0;
      wr_count_q  <= WR_COUNT_RST;
    end else begin
      trace_valid <= we_eff;
      if (we_eff) begin
        trace_pc   <= wb.PC_W;
        trace_addr <= wb.A3;
        trace_data <= wb.WData;
        wr_count_q <= wr_count_q + 32'd1;
      end
    end
  end

  assign wr_count = wr_count_q;

  grf_read_port #(.DW(DW)) u_rp1 (
    .addr     (A1),
    .arr_data (regs[A1]),
    .we_eff   (we_byp),
    .wr_addr  (wb.A3),
    .wr_data  (wb.WData),
    .rd       (RD1)
  );

  grf_read_port #(.DW(DW)) u_rp2 (
    .addr     (A2),
    .arr_data (regs[A2]),
    .we_eff   (we_byp),
    .wr_addr  (wb.A3),
    .wr_data  (wb.WData),
    .rd       (RD2)
  );

endmodule

// File: tb/tb_grf_writeback_sink.sv
module tb_grf_writeback_sink;

`ifdef GRF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic [4:0]  A1;
  logic [4:0]  A2;
  logic [31:0] RD1;
  logic [31:0] RD2;
  logic        trace_valid;
  logic [31:0] trace_pc;
  logic [4:0]  trace_addr;
  logic [31:0] trace_data;
  logic [31:0] wr_count;

  int checks;
  int errors;

  grf_writeback_sink_if #(.DW(32)) wb ();

  grf_writeback_sink dut (
    .clk         (clk),
    .reset       (reset),
    .A1          (A1),
    .A2          (A2),
    .RD1         (RD1),
    .RD2         (RD2),
    .wb          (wb),
    .trace_valid (trace_valid),
    .trace_pc    (trace_pc),
    .trace_addr  (trace_addr),
    .trace_data  (trace_data),
    .wr_count    (wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive_wr(input logic we, input logic [4:0] a3,
                          input logic [31:0] d, input logic [31:0] pc);
    wb.RFWr  = we;
    wb.A3    = a3;
    wb.WData = d;
    wb.PC_W  = pc;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    A1 = 5'd0;
    A2 = 5'd0;
    drive_wr(1'b0, 5'd0, 32'h0, 32'h0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;

    // Reset state on both ports for every register
    for (int a = 0; a < 32; a++) begin
      A1 = 5'(a);
      A2 = 5'(31 - a);
      #1;
      check("rst_rd1", RD1, 32'h0);
      check("rst_rd2", RD2, 32'h0);
    end
    check("rst_tvalid", {31'b0, trace_valid}, 32'h0);
    check("rst_tpc", trace_pc, 32'h0);
    check("rst_taddr", {27'b0, trace_addr}, 32'h0);
    check("rst_tdata", trace_data, 32'h0);
    check("rst_count", wr_count, 32'h0);

    // Single write to $5
    @(negedge clk);
    drive_wr(1'b1, 5'd5, 32'h1234_5678, 32'h0000_3000);
    A1 = 5'd5;
    A2 = 5'd0;
    #1;
    check("w5_same_rd1", RD1, BYP ? 32'h1234_5678 : 32'h0);
    check("w5_same_rd2", RD2, 32'h0);
    check("w5_same_tvalid", {31'b0, trace_valid}, 32'h0);
    @(posedge clk);
    #1;
    check("w5_next_rd1", RD1, 32'h1234_5678);
    check("w5_tvalid", {31'b0, trace_valid}, 32'h1);
    check("w5_tpc", trace_pc, 32'h0000_3000);
    check("w5_taddr", {27'b0, trace_addr}, 32'd5);
    check("w5_tdata", trace_data, 32'h1234_5678);
    check("w5_count", wr_count, 32'd1);
    @(negedge clk);
    drive_wr(1'b0, 5'd0, 32'h0, 32'h0);
    @(posedge clk);
    #1;
    check("w5_pulse_end", {31'b0, trace_valid}, 32'h0);
    check("w5_taddr_hold", {27'b0, trace_addr}, 32'd5);
    check("w5_tdata_hold", trace_data, 32'h1234_5678);
    check("w5_rd1_kept", RD1, 32'h1234_5678);

    // Write attempt to $0 is silent
    @(negedge clk);
    drive_wr(1'b1, 5'd0, 32'hFFFF_FFFF, 32'h0000_3004);
    A1 = 5'd0;
    A2 = 5'd0;
    #1;
    check("w0_same_rd1", RD1, 32'h0);
    check("w0_same_rd2", RD2, 32'h0);
    @(posedge clk);
    #1;
    check("w0_next_rd1", RD1, 32'h0);
    check("w0_next_rd2", RD2, 32'h0);
    check("w0_tvalid", {31'b0, trace_valid}, 32'h0);
    check("w0_count", wr_count, 32'd1);
    check("w0_taddr_hold", {27'b0, trace_addr}, 32'd5);

    // Back-to-back writes to $1, $2, $3 with both ports reading $2
    @(negedge clk);
    A1 = 5'd2;
    A2 = 5'd2;
    drive_wr(1'b1, 5'd1, 32'h0000_0011, 32'h0000_3008);
    @(posedge clk);
    #1;
    check("b1_tvalid", {31'b0, trace_valid}, 32'h1);
    check("b1_taddr", {27'b0, trace_addr}, 32'd1);
    check("b1_tdata", trace_data, 32'h0000_0011);
    check("b1_rd1", RD1, 32'h0);
    check("b1_rd2", RD2, 32'h0);
    @(negedge clk);
    drive_wr(1'b1, 5'd2, 32'h0000_0022, 32'h0000_300C);
    #1;
    check("b2_same_rd1", RD1, BYP ? 32'h0000_0022 : 32'h0);
    check("b2_same_rd2", RD2, BYP ? 32'h0000_0022 : 32'h0);
    @(posedge clk);
    #1;
    check("b2_tvalid", {31'b0, trace_valid}, 32'h1);
    check("b2_taddr", {27'b0, trace_addr}, 32'd2);
    check("b2_tpc", trace_pc, 32'h0000_300C);
    check("b2_rd1", RD1, 32'h0000_0022);
    check("b2_rd2", RD2, 32'h0000_0022);
    @(negedge clk);
    drive_wr(1'b1, 5'd3, 32'h0000_0033, 32'h0000_3010);
    #1;
    check("b3_same_rd1", RD1, 32'h0000_0022);
    @(posedge clk);
    #1;
    check("b3_tvalid", {31'b0, trace_valid}, 32'h1);
    check("b3_taddr", {27'b0, trace_addr}, 32'd3);
    check("b3_tdata", trace_data, 32'h0000_0033);
    check("b3_count", wr_count, 32'd4);
    @(negedge clk);
    drive_wr(1'b0, 5'd0, 32'h0, 32'h0);
    A1 = 5'd1;
    A2 = 5'd3;
    #1;
    check("arr_r1", RD1, 32'h0000_0011);
    check("arr_r3", RD2, 32'h0000_0033);
    @(posedge clk);
    #1;
    check("b_pulse_end", {31'b0, trace_valid}, 32'h0);

    // Write $7 then asynchronous reset in the middle of the low phase
    @(negedge clk);
    drive_wr(1'b1, 5'd7, 32'h0000_00AA, 32'h0000_3014);
    @(posedge clk);
    @(negedge clk);
    drive_wr(1'b0, 5'd0, 32'h0, 32'h0);
    A1 = 5'd7;
    A2 = 5'd5;
    #1;
    check("r7_before", RD1, 32'h0000_00AA);
    check("r7_tvalid", {31'b0, trace_valid}, 32'h1);
    #1;
    reset = 1'b1;
    #1;
    check("arst_rd1", RD1, 32'h0);
    check("arst_rd2", RD2, 32'h0);
    check("arst_tvalid", {31'b0, trace_valid}, 32'h0);
    check("arst_count", wr_count, 32'h0);
    check("arst_tpc", trace_pc, 32'h0);
    check("arst_tdata", trace_data, 32'h0);
    // Bypass is masked while reset is held, and held reset blocks the write
    drive_wr(1'b1, 5'd7, 32'h0000_0055, 32'h0000_3018);
    #1;
    check("arst_byp_mask", RD1, 32'h0);
    @(posedge clk);
    #1;
    check("arst_edge_rd1", RD1, 32'h0);
    check("arst_edge_count", wr_count, 32'h0);
    check("arst_edge_tvalid", {31'b0, trace_valid}, 32'h0);

    // First edge after release takes the write
    @(negedge clk);
    reset = 1'b0;
    drive_wr(1'b1, 5'd6, 32'h0000_0066, 32'h0000_301C);
    A1 = 5'd6;
    @(posedge clk);
    #1;
    check("rel_rd1", RD1, 32'h0000_0066);
    check("rel_count", wr_count, 32'd1);
    check("rel_tvalid", {31'b0, trace_valid}, 32'h1);

    // Counter wrap from all ones
    @(negedge clk);
    drive_wr(1'b0, 5'd0, 32'h0, 32'h0);
    force dut.wr_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.wr_count_q;
    #1;
    check("wrap_preload", wr_count, 32'hFFFF_FFFF);
    @(posedge clk);
    @(negedge clk);
    drive_wr(1'b1, 5'd4, 32'hDEAD_BEEF, 32'h0000_4000);
    A1 = 5'd4;
    A2 = 5'd4;
    @(posedge clk);
    #1;
    check("wrap_count", wr_count, 32'h0);
    check("wrap_rd1", RD1, 32'hDEAD_BEEF);
    check("wrap_rd2", RD2, 32'hDEAD_BEEF);
    check("wrap_tvalid", {31'b0, trace_valid}, 32'h1);
    check("wrap_tpc", trace_pc, 32'h0000_4000);
    check("wrap_taddr", {27'b0, trace_addr}, 32'd4);
    check("wrap_tdata", trace_data, 32'hDEAD_BEEF);
    @(negedge clk);
    drive_wr(1'b0, 5'd0, 32'h0, 32'h0);
    @(posedge clk);
    #1;
    check("wrap_pulse_end", {31'b0, trace_valid}, 32'h0);
    check("wrap_count_hold", wr_count, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
